// File: rtl/dbi_pkg.sv
// Shared definitions for the DBI panel responder: command codes, FSM state,
// pixel format and the register context carried by the top-level FSM.
package dbi_pkg;

  localparam logic [7:0] CMD_SWRESET = 8'h01;
  localparam logic [7:0] CMD_RDDID   = 8'h04;
  localparam logic [7:0] CMD_CASET   = 8'h2A;
  localparam logic [7:0] CMD_PASET   = 8'h2B;
  localparam logic [7:0] CMD_RAMWR   = 8'h2C;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CASET,
    S_PASET,
    S_RAMWR,
    S_RDID
  } state_t;

  // RGB565: the first bus byte lands in [15:8].
  typedef struct packed {
    logic [4:0] r;
    logic [5:0] g;
    logic [4:0] b;
  } rgb565_t;

  // Command-side state: address window, write cursor, partial bytes.
  typedef struct packed {
    state_t      state;
    logic [15:0] sc;
    logic [15:0] ec;
    logic [15:0] sp;
    logic [15:0] ep;
    logic [15:0] x;
    logic [15:0] y;
    logic        byte_phase;
    logic [1:0]  param_cnt;
    logic [23:0] param_buf;
    logic [7:0]  hi_byte;
    logic [2:0]  rd_idx;
  } ctx_t;

  // Registered outputs toward the pixel port and the bus.
  typedef struct packed {
    logic        valid;
    logic [15:0] x;
    logic [15:0] y;
    rgb565_t     data;
    logic [7:0]  dout;
    logic        doe;
  } out_t;

endpackage

// File: rtl/dbi_bus_sync.sv
// Brings the asynchronous 8080 bus strobes into the clock domain and turns
// them into single-cycle events. data_in is sampled every clock; the master
// holds it stable for several clocks around wrx, so the sample taken while
// the synchronised strobe edge is seen belongs to that write.
module dbi_bus_sync (
  input  logic       clock,
  input  logic       reset,
  input  logic       csx,
  input  logic       resx,
  input  logic       dcx,
  input  logic       wrx,
  input  logic       rdx,
  input  logic [7:0] data_in,
  output logic       wr_evt,
  output logic       rd_start,
  output logic       rd_end,
  output logic       cs_rise,
  output logic       resx_s,
  output logic       wr_dcx,
  output logic [7:0] wr_data
);

  // [0] first flop, [1] synchronised level, [2] previous synchronised level
  logic [2:0] csx_sr;
  logic [2:0] wrx_sr;
  logic [2:0] rdx_sr;
  logic [1:0] resx_sr;
  logic [1:0] dcx_sr;

  // Synchroniser chains and data sample; strobes reset to their idle (high) level.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge value of its neighbour; blocking here would collapse the chain.
  always_ff @(posedge clock) begin
    if (reset) begin
      csx_sr  <= 3'b111;
      wrx_sr  <= 3'b111;
      rdx_sr  <= 3'b111;
      resx_sr <= 2'b11;
      dcx_sr  <= 2'b00;
      wr_data <= 8'h00;
    end else begin
      csx_sr  <= {csx_sr[1:0], csx};
      wrx_sr  <= {wrx_sr[1:0], wrx};
      rdx_sr  <= {rdx_sr[1:0], rdx};
      resx_sr <= {resx_sr[0], resx};
      dcx_sr  <= {dcx_sr[0], dcx};
      wr_data <= data_in;
    end
  end

  assign wr_evt   = wrx_sr[1] & ~wrx_sr[2] & ~csx_sr[1];
  assign rd_start = ~rdx_sr[1] & rdx_sr[2] & ~csx_sr[1];
  assign rd_end   = rdx_sr[1] & ~rdx_sr[2];
  assign cs_rise  = csx_sr[1] & ~csx_sr[2];
  assign resx_s   = resx_sr[1];
  assign wr_dcx   = dcx_sr[1];

endmodule

// File: rtl/dbi_panel_responder.sv
// Panel-side responder for the 8080-style DBI bus: decodes commands, tracks
// the CASET/PASET window and streams RAMWR pixels out with coordinates.
// Optional: define DBI_RESPONDER_RDID_EN to enable the RDDID read path;
// without it 0x04 is an unknown command and data_out/data_oe stay 0.
module dbi_panel_responder
  import dbi_pkg::*;
#(
  parameter int          WIDTH    = 240,
  parameter int          HEIGHT   = 320,
  parameter logic [23:0] ID_BYTES = 24'h009341
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        csx,
  input  logic        resx,
  input  logic        dcx,
  input  logic        wrx,
  input  logic        rdx,
  input  logic [7:0]  data_in,
  output logic [7:0]  data_out,
  output logic        data_oe,
  output logic        pix_valid,
  output logic [15:0] pix_x,
  output logic [15:0] pix_y,
  output logic [15:0] pix_data
);

  logic       wr_evt, rd_start, rd_end, cs_rise, resx_s, wr_dcx;
  logic [7:0] wr_data;

  ctx_t c, c_n;
  out_t o, o_n;

  dbi_bus_sync u_sync (
    .clock    (clock),
    .reset    (reset),
    .csx      (csx),
    .resx     (resx),
    .dcx      (dcx),
    .wrx      (wrx),
    .rdx      (rdx),
    .data_in  (data_in),
    .wr_evt   (wr_evt),
    .rd_start (rd_start),
    .rd_end   (rd_end),
    .cs_rise  (cs_rise),
    .resx_s   (resx_s),
    .wr_dcx   (wr_dcx),
    .wr_data  (wr_data)
  );

  // Power-on / SWRESET / resx context: full-panel window, cursor at origin.
  function automatic ctx_t ctx_reset();
    ctx_t r;
    r       = '0;
    r.state = S_IDLE;
    r.ec    = 16'(WIDTH - 1);
    r.ep    = 16'(HEIGHT - 1);
    return r;
  endfunction

  // Context and output registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      c <= ctx_reset();
      o <= '0;
    end else begin
      c <= c_n;
      o <= o_n;
    end
  end

  // Next-state: command decode, parameter collection, pixel assembly, reads.
  // NOTE: every field gets a default before any branch, so no path leaves a
  // value unassigned and no latch is inferred.
  always_comb begin
    c_n       = c;
    o_n       = o;
    o_n.valid = 1'b0;

    if (!resx_s) begin
      c_n = ctx_reset();
      o_n = '0;
    end else begin
      if (wr_evt) begin
        if (!wr_dcx) begin
          c_n.param_cnt  = 2'd0;
          c_n.byte_phase = 1'b0;
          case (wr_data)
            CMD_CASET: c_n.state = S_CASET;
            CMD_PASET: c_n.state = S_PASET;
            CMD_RAMWR: begin
              c_n.state = S_RAMWR;
              c_n.x     = c.sc;
              c_n.y     = c.sp;
            end
`ifdef DBI_RESPONDER_RDID_EN
            CMD_RDDID: begin
              c_n.state  = S_RDID;
              c_n.rd_idx = 3'd0;
            end
`endif
            CMD_SWRESET: begin
              c_n = ctx_reset();
              o_n = '0;
            end
            default: c_n.state = S_IDLE;
          endcase
        end else begin
          case (c.state)
            S_CASET, S_PASET: begin
              c_n.param_buf = {c.param_buf[15:0], wr_data};
              c_n.param_cnt = c.param_cnt + 2'd1;
              if (c.param_cnt == 2'd3) begin
                // start and end commit together on the last byte
                if (c.state == S_CASET) begin
                  c_n.sc = c.param_buf[23:8];
                  c_n.ec = {c.param_buf[7:0], wr_data};
                end else begin
                  c_n.sp = c.param_buf[23:8];
                  c_n.ep = {c.param_buf[7:0], wr_data};
                end
                c_n.state = S_IDLE;
              end
            end
            S_RAMWR: begin
              if (!c.byte_phase) begin
                c_n.hi_byte    = wr_data;
                c_n.byte_phase = 1'b1;
              end else begin
                c_n.byte_phase = 1'b0;
                // an inverted window swallows bytes without writing
                if (c.sc <= c.ec && c.sp <= c.ep) begin
                  o_n.valid = 1'b1;
                  o_n.x     = c.x;
                  o_n.y     = c.y;
                  o_n.data  = rgb565_t'({c.hi_byte, wr_data});
                  if (c.x == c.ec) begin
                    c_n.x = c.sc;
                    c_n.y = (c.y == c.ep) ? c.sp : c.y + 16'd1;
                  end else begin
                    c_n.x = c.x + 16'd1;
                  end
                end
              end
            end
            default: ;
          endcase
        end
      end
`ifdef DBI_RESPONDER_RDID_EN
      // a simultaneous write takes priority and the read start is dropped
      else if (rd_start && c.state == S_RDID) begin
        o_n.doe = 1'b1;
        case (c.rd_idx)
          3'd1:    o_n.dout = ID_BYTES[23:16];
          3'd2:    o_n.dout = ID_BYTES[15:8];
          3'd3:    o_n.dout = ID_BYTES[7:0];
          default: o_n.dout = 8'h00;
        endcase
        if (c.rd_idx < 3'd4) c_n.rd_idx = c.rd_idx + 3'd1;
      end
      if (rd_end) o_n.doe = 1'b0;
`endif
      // deselect drops a half pixel but keeps the command state
      if (cs_rise) c_n.byte_phase = 1'b0;
    end
  end

`ifndef DBI_RESPONDER_RDID_EN
  logic unused_rd;
  assign unused_rd = ^{rd_start, rd_end, ID_BYTES};
`endif

  assign pix_valid = o.valid;
  assign pix_x     = o.x;
  assign pix_y     = o.y;
  assign pix_data  = o.data;
  assign data_out  = o.dout;
  assign data_oe   = o.doe;

endmodule

// File: tb/tb_dbi_panel_responder.sv
// Self-checking bench for dbi_panel_responder: drives the 8080 bus with
// slow strobes and checks emitted pixels against a scoreboard queue.
module tb_dbi_panel_responder;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        csx = 1'b1;
  logic        resx = 1'b1;
  logic        dcx = 1'b1;
  logic        wrx = 1'b1;
  logic        rdx = 1'b1;
  logic [7:0]  data_in = 8'h00;
  logic [7:0]  data_out;
  logic        data_oe;
  logic        pix_valid;
  logic [15:0] pix_x, pix_y, pix_data;

  int vectors = 0;
  int miscompares = 0;

  typedef struct packed {
    logic [15:0] x;
    logic [15:0] y;
    logic [15:0] d;
  } pix_t;

  pix_t exp_q[$];
  logic prev_valid = 1'b0;

  dbi_panel_responder dut (
    .clock     (clock),
    .reset     (reset),
    .csx       (csx),
    .resx      (resx),
    .dcx       (dcx),
    .wrx       (wrx),
    .rdx       (rdx),
    .data_in   (data_in),
    .data_out  (data_out),
    .data_oe   (data_oe),
    .pix_valid (pix_valid),
    .pix_x     (pix_x),
    .pix_y     (pix_y),
    .pix_data  (pix_data)
  );

  always #5 clock = ~clock;

  // Scoreboard: every pixel pulse must be single-cycle and match the queue head.
  always @(negedge clock) begin
    pix_t e;
    if (pix_valid) begin
      vectors++;
      if (prev_valid) begin
        miscompares++;
        $display("FAIL pix_width: pix_valid high two cycles in a row, required one-cycle pulse");
      end else if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL pix_unexpected: got (%0d,%0d)=%h, required no pixel", pix_x, pix_y, pix_data);
      end else begin
        e = exp_q.pop_front();
        if ({pix_x, pix_y, pix_data} !== e)
          begin
            miscompares++;
            $display("FAIL pix_value: got (%0d,%0d)=%h, required (%0d,%0d)=%h",
                     pix_x, pix_y, pix_data, e.x, e.y, e.d);
          end
      end
    end
    prev_valid = pix_valid;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic wr(input logic dc, input logic [7:0] b);
    dcx = dc;
    data_in = b;
    wrx = 1'b0;
    tick(4);
    wrx = 1'b1;
    tick(4);
  endtask

  task automatic cmd(input logic [7:0] b);
    wr(1'b0, b);
  endtask

  task automatic par(input logic [7:0] b);
    wr(1'b1, b);
  endtask

  task automatic push(input int x, input int y, input logic [15:0] d);
    exp_q.push_back({16'(x), 16'(y), d});
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    tick(3);
    reset = 1'b0;
    tick(3);
  endtask

  task automatic set_window(input logic [15:0] sc, input logic [15:0] ec,
                            input logic [15:0] sp, input logic [15:0] ep);
    cmd(8'h2A);
    par(sc[15:8]); par(sc[7:0]); par(ec[15:8]); par(ec[7:0]);
    cmd(8'h2B);
    par(sp[15:8]); par(sp[7:0]); par(ep[15:8]); par(ep[7:0]);
  endtask

  task automatic send_pixel(input logic [15:0] d);
    par(d[15:8]);
    par(d[7:0]);
  endtask

  task automatic test_reset();
    pulse_reset();
    vectors++;
    if (pix_valid !== 1'b0 || data_oe !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_ctrl: pix_valid=%b data_oe=%b, required 0 0", pix_valid, data_oe);
    end
    vectors++;
    if ({pix_x, pix_y, pix_data} !== 48'h0) begin
      miscompares++;
      $display("FAIL reset_pix: got (%0d,%0d)=%h, required (0,0)=0000", pix_x, pix_y, pix_data);
    end
    vectors++;
    if (data_out !== 8'h00) begin
      miscompares++;
      $display("FAIL reset_dout: got %h, required 00", data_out);
    end
  endtask

  task automatic test_basic_window();
    logic [7:0] hi, lo;
    csx = 1'b0;
    set_window(16'd0, 16'd3, 16'd0, 16'd1);
    cmd(8'h2C);
    for (int k = 0; k < 8; k++) begin
      hi = 8'(8'h10 + 2 * k);
      lo = 8'(8'h11 + 2 * k);
      push(k % 4, k / 4, {hi, lo});
      par(hi);
      par(lo);
    end
    tick(10);
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL basic_drain: %0d pixels outstanding, required 0", exp_q.size());
    end
    exp_q.delete();
  endtask

  task automatic test_frame_wrap();
    logic [15:0] d;
    set_window(16'd0, 16'd1, 16'd0, 16'd0);
    cmd(8'h2C);
    for (int k = 0; k < 6; k++) begin
      d = 16'($urandom);
      push(k % 2, 0, d);
      send_pixel(d);
    end
    tick(10);
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL wrap_drain: %0d pixels outstanding, required 0", exp_q.size());
    end
    exp_q.delete();
  endtask

  task automatic test_cs_discard();
    pulse_reset();
    cmd(8'h2C);
    par(8'hF8);
    csx = 1'b1;
    tick(6);
    csx = 1'b0;
    tick(4);
    push(0, 0, 16'h001F);
    par(8'h00);
    par(8'h1F);
    tick(10);
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL cs_drain: %0d pixels outstanding, required 0", exp_q.size());
    end
    exp_q.delete();
  endtask

  task automatic test_short_caset();
    pulse_reset();
    cmd(8'h2A);
    par(8'h00); par(8'h05); par(8'h00);
    cmd(8'h2C);
    push(0, 0, 16'hA1B2);
    push(1, 0, 16'hC3D4);
    send_pixel(16'hA1B2);
    send_pixel(16'hC3D4);
    tick(10);
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL short_caset_drain: %0d pixels outstanding, required 0", exp_q.size());
    end
    exp_q.delete();
  endtask

  task automatic test_swreset();
    set_window(16'd2, 16'd3, 16'd4, 16'd5);
    cmd(8'h2C);
    push(2, 4, 16'h5A5A);
    send_pixel(16'h5A5A);
    tick(4);
    cmd(8'h01);
    vectors++;
    if ({pix_x, pix_y, pix_data} !== 48'h0) begin
      miscompares++;
      $display("FAIL swreset_pix: got (%0d,%0d)=%h, required (0,0)=0000", pix_x, pix_y, pix_data);
    end
    cmd(8'h2C);
    push(0, 0, 16'h1357);
    send_pixel(16'h1357);
    tick(10);
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL swreset_drain: %0d pixels outstanding, required 0", exp_q.size());
    end
    exp_q.delete();
  endtask

  task automatic test_invalid_and_unknown();
    pulse_reset();
    // inverted column window: bytes consumed, no pixels
    set_window(16'd5, 16'd2, 16'd0, 16'd0);
    cmd(8'h2C);
    send_pixel(16'hDEAD);
    send_pixel(16'hBEEF);
    // unknown command in the middle of a pixel drops it and the following data
    pulse_reset();
    cmd(8'h2C);
    par(8'hAA);
    cmd(8'h00);
    par(8'h12); par(8'h34);
    cmd(8'h04);
    par(8'h56); par(8'h78);
    cmd(8'h2C);
    push(0, 0, 16'h1234);
    send_pixel(16'h1234);
    tick(10);
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL unknown_drain: %0d pixels outstanding, required 0", exp_q.size());
    end
    exp_q.delete();
  endtask

  task automatic test_resx();
    pulse_reset();
    set_window(16'd5, 16'd6, 16'd2, 16'd2);
    cmd(8'h2C);
    par(8'hAB);
    resx = 1'b0;
    tick(6);
    resx = 1'b1;
    tick(6);
    // window back to 0..239 x 0..319: column wrap after x=239 moves to row 1
    cmd(8'h2C);
    for (int k = 0; k < 241; k++) begin
      push(k % 240, k / 240, 16'(k * 3 + 1));
      send_pixel(16'(k * 3 + 1));
    end
    tick(10);
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL resx_drain: %0d pixels outstanding, required 0", exp_q.size());
    end
    exp_q.delete();
  endtask

`ifdef DBI_RESPONDER_RDID_EN
  task automatic test_rdid();
    logic [7:0] exp_b [5];
    exp_b = '{8'h00, 8'h00, 8'h93, 8'h41, 8'h00};
    pulse_reset();
    cmd(8'h04);
    for (int i = 0; i < 5; i++) begin
      rdx = 1'b0;
      tick(2);
      vectors++;
      if (data_oe !== 1'b0) begin
        miscompares++;
        $display("FAIL rdid_oe_early[%0d]: got %b, required 0", i, data_oe);
      end
      tick(1);
      vectors++;
      if (data_oe !== 1'b1 || data_out !== exp_b[i]) begin
        miscompares++;
        $display("FAIL rdid_byte[%0d]: oe=%b data=%h, required oe=1 data=%h",
                 i, data_oe, data_out, exp_b[i]);
      end
      rdx = 1'b1;
      tick(2);
      vectors++;
      if (data_oe !== 1'b1) begin
        miscompares++;
        $display("FAIL rdid_oe_hold[%0d]: got %b, required 1", i, data_oe);
      end
      tick(1);
      vectors++;
      if (data_oe !== 1'b0) begin
        miscompares++;
        $display("FAIL rdid_oe_release[%0d]: got %b, required 0", i, data_oe);
      end
      tick(2);
    end
  endtask
`else
  task automatic test_rdid();
    pulse_reset();
    cmd(8'h04);
    for (int i = 0; i < 2; i++) begin
      rdx = 1'b0;
      tick(4);
      vectors++;
      if (data_oe !== 1'b0 || data_out !== 8'h00) begin
        miscompares++;
        $display("FAIL rdid_disabled[%0d]: oe=%b data=%h, required oe=0 data=00",
                 i, data_oe, data_out);
      end
      rdx = 1'b1;
      tick(4);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic_window();
    test_frame_wrap();
    test_cs_discard();
    test_short_caset();
    test_swreset();
    test_invalid_and_unknown();
    test_resx();
    test_rdid();
    test_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
